// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution datapath.
package conv_pkg;

  localparam int unsigned K      = 5;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned ROW_W  = 20;
  localparam int unsigned SUM_W  = 23;

  typedef logic [7:0]          pixel_t;
  typedef pixel_t [4:0][4:0]   kernel_t;
  typedef logic signed [7:0]   coef_t;
  typedef coef_t [4:0][4:0]    coeff_t;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ROW_W-1:0]  row_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  typedef struct packed {
    logic user;
    logic last;
  } flags_t;

endpackage

// File: rtl/conv_reduce_sat.sv
// Rounds (half-up), arithmetically shifts and clamps a weighted sum to a pixel.
module conv_reduce_sat
  import conv_pkg::*;
#(
  parameter int unsigned SHIFT = 4
) (
  input  sum_t   sum_i,
  output pixel_t pix_o
);

  localparam int unsigned RND_I = (SHIFT > 0) ? (32'd1 << (SHIFT - 1)) : 32'd0;
  localparam logic signed [SUM_W:0] RND  = (SUM_W + 1)'(RND_I);
  localparam logic signed [SUM_W:0] PMAX = (SUM_W + 1)'(255);

  logic signed [SUM_W:0] rnd;
  logic signed [SUM_W:0] shd;

  // One guard bit so the rounding term can never wrap the sum.
  always_comb begin
    rnd   = $signed({sum_i[SUM_W-1], sum_i}) + RND;
    shd   = rnd >>> SHIFT;
    pix_o = '0;
    if (shd[SUM_W])
      pix_o = '0;
    else if (shd > PMAX)
      pix_o = '1;
    else
      pix_o = shd[7:0];
  end

endmodule

// File: rtl/conv_reduce.sv
// 5x5 weighted-sum reduction with rounding/saturation and regenerated
// AXI-stream framing; three bubble-collapsing stages (S1 products, S2 rows, OUT).
module conv_reduce
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned SHIFT = 4
) (
  input  logic    clk,
  input  logic    arst_n,
  input  logic    s_tvalid_i,
  input  kernel_t s_tdata_i,
  output logic    s_tready_o,
  input  coeff_t  coeff_i,
  input  logic    m_tready_i,
  output logic    m_tvalid_o,
  output pixel_t  m_tdata_o,
  output logic    m_tuser_o,
  output logic    m_tlast_o,
  output logic    busy_o
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last, row_last;

  logic vld_s1, vld_s2, vld_out;
  logic rdy_s1, rdy_s2, rdy_out;
  logic acc, adv_s2, adv_out;

  prod_t  prod_c [K][K];
  prod_t  prod_q [K][K];
  row_t   rsum_c [K];
  row_t   rsum_q [K];
  sum_t   total;
  pixel_t pix_c;
  flags_t flg_c, s1_f, s2_f;

  assign rdy_out    = !vld_out || m_tready_i;
  assign rdy_s2     = !vld_s2  || rdy_out;
  assign rdy_s1     = !vld_s1  || rdy_s2;
  assign s_tready_o = rdy_s1;
  assign busy_o     = vld_s1 | vld_s2 | vld_out;
  assign m_tvalid_o = vld_out;

  assign acc     = s_tvalid_i && rdy_s1;
  assign adv_s2  = vld_s1 && rdy_s2;
  assign adv_out = vld_s2 && rdy_out;

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));

  always_comb begin
    flg_c.user = (col == '0) && (row == '0);
    flg_c.last = col_last;
  end

  always_comb begin
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K; c++)
        prod_c[r][c] = PROD_W'($signed({1'b0, s_tdata_i[r][c]})) *
                       PROD_W'($signed(coeff_i[r][c]));
  end

  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      rsum_c[r] = '0;
      for (int unsigned c = 0; c < K; c++)
        rsum_c[r] = rsum_c[r] + ROW_W'(prod_q[r][c]);
    end
  end

  always_comb begin
    total = '0;
    for (int unsigned r = 0; r < K; r++)
      total = total + SUM_W'(rsum_q[r]);
  end

  conv_reduce_sat #(.SHIFT(SHIFT)) u_sat (
    .sum_i (total),
    .pix_o (pix_c)
  );

  // A stage reloads whenever it can move; the incoming valid decides occupancy.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_s1  <= 1'b0;
      vld_s2  <= 1'b0;
      vld_out <= 1'b0;
    end else begin
      if (rdy_s1)  vld_s1  <= s_tvalid_i;
      if (rdy_s2)  vld_s2  <= vld_s1;
      if (rdy_out) vld_out <= vld_s2;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      prod_q <= prod_c;
      s1_f   <= flg_c;
    end
    if (adv_s2) begin
      rsum_q <= rsum_c;
      s2_f   <= s1_f;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_tdata_o <= '0;
      m_tuser_o <= 1'b0;
      m_tlast_o <= 1'b0;
    end else if (adv_out) begin
      m_tdata_o <= pix_c;
      m_tuser_o <= s2_f.user;
      m_tlast_o <= s2_f.last;
    end
  end

endmodule
